cpu_sequencer: RTL and testbench

Control FSM for the simple RISC datapath. It sits directly upstream of the ALU and drives its `ALUop` input, along with every other datapath control signal. It latches an instruction word on a start handshake, decodes it, and steps the datapath through register read, operate and write-back. It then returns to an idle wait state with `w` high.

---
 rtl/cpu_pkg.sv | 58 +++++
 rtl/cpu_sequencer_if.sv | 32 +++
 rtl/cpu_decode.sv | 68 ++++++
 rtl/cpu_sequencer.sv | 125 ++++++++++++
 tb/tb_cpu_sequencer.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared types and constants for the RISC control sequencer: FSM states,
// instruction classes, opcode/op encodings, ALU operations and field positions.
package cpu_pkg;

  typedef enum logic [2:0] {
    ST_WAIT      = 3'd0,
    ST_DECODE    = 3'd1,
    ST_GET_A     = 3'd2,
    ST_GET_B     = 3'd3,
    ST_ALU       = 3'd4,
    ST_WRITE_REG = 3'd5,
    ST_WRITE_IMM = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    CL_MOVI    = 3'd0,
    CL_MOVR    = 3'd1,
    CL_ALU3    = 3'd2,
    CL_CMP     = 3'd3,
    CL_MVN     = 3'd4,
    CL_ILLEGAL = 3'd5
  } iclass_t;

  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;

  localparam logic [1:0] OP_MOVI = 2'b10;
  localparam logic [1:0] OP_MOVR = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_CMP  = 2'b01;
  localparam logic [1:0] OP_AND  = 2'b10;
  localparam logic [1:0] OP_MVN  = 2'b11;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_AND  = 2'b10;
  localparam logic [1:0] ALU_NOTB = 2'b11;

  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 13;
  localparam int OP_MSB  = 12;
  localparam int OP_LSB  = 11;
  localparam int RN_MSB  = 10;
  localparam int RN_LSB  = 8;
  localparam int RD_MSB  = 7;
  localparam int RD_LSB  = 5;
  localparam int SH_MSB  = 4;
  localparam int SH_LSB  = 3;
  localparam int RM_MSB  = 2;
  localparam int RM_LSB  = 0;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

  function automatic logic [15:0] sext8(input logic [7:0] v);
    return {{8{v[7]}}, v};
  endfunction

endpackage

// File: rtl/cpu_sequencer_if.sv
// Handshake and datapath-control bundle between the sequencer (slave) and
// whatever issues instructions and consumes the control lines (master).
interface cpu_sequencer_if;
  logic        s;
  logic [15:0] instr;
  logic        w;
  logic        illegal;
  logic [2:0]  rnum;
  logic        write;
  logic        vsel;
  logic        loada;
  logic        loadb;
  logic        loadc;
  logic        loads;
  logic        asel;
  logic [1:0]  shift;
  logic [1:0]  ALUop;
  logic [15:0] sximm8;
  logic [15:0] retire_count;

  modport master (
    output s, instr,
    input  w, illegal, rnum, write, vsel, loada, loadb, loadc, loads,
           asel, shift, ALUop, sximm8, retire_count
  );

  modport slave (
    input  s, instr,
    output w, illegal, rnum, write, vsel, loada, loadb, loadc, loads,
           asel, shift, ALUop, sximm8, retire_count
  );
endinterface

// File: rtl/cpu_decode.sv
// Combinational instruction decoder: splits the latched word into fields,
// classifies it and maps it onto an ALU operation.
module cpu_decode
  import cpu_pkg::*;
(
  input  logic [15:0] ir_i,
  output logic [2:0]  rn_o,
  output logic [2:0]  rd_o,
  output logic [2:0]  rm_o,
  output logic [1:0]  sh_o,
  output logic [15:0] sximm8_o,
  output iclass_t     iclass_o,
  output logic [1:0]  alu_op_o
);

  logic [2:0] opc_s;
  logic [1:0] op_s;

  assign opc_s    = ir_i[OPC_MSB:OPC_LSB];
  assign op_s     = ir_i[OP_MSB:OP_LSB];
  assign rn_o     = ir_i[RN_MSB:RN_LSB];
  assign rd_o     = ir_i[RD_MSB:RD_LSB];
  assign rm_o     = ir_i[RM_MSB:RM_LSB];
  assign sh_o     = ir_i[SH_MSB:SH_LSB];
  assign sximm8_o = sext8(ir_i[IMM_MSB:IMM_LSB]);

  // Instruction class from opcode/op; anything unlisted is illegal.
  always_comb begin
    iclass_o = CL_ILLEGAL;
    case (opc_s)
      OPC_MOV: begin
        case (op_s)
          OP_MOVI: iclass_o = CL_MOVI;
          OP_MOVR: iclass_o = CL_MOVR;
          default: iclass_o = CL_ILLEGAL;
        endcase
      end
      OPC_ALU: begin
        case (op_s)
          OP_ADD:  iclass_o = CL_ALU3;
          OP_CMP:  iclass_o = CL_CMP;
          OP_AND:  iclass_o = CL_ALU3;
          OP_MVN:  iclass_o = CL_MVN;
          default: iclass_o = CL_ILLEGAL;
        endcase
      end
      default: iclass_o = CL_ILLEGAL;
    endcase
  end

  // MOV reg rides the adder as 0 + B, so it shares ALU_ADD with ADD.
  always_comb begin
    alu_op_o = ALU_ADD;
    case (iclass_o)
      CL_ALU3: begin
        if (op_s == OP_AND) begin
          alu_op_o = ALU_AND;
        end else begin
          alu_op_o = ALU_ADD;
        end
      end
      CL_CMP:  alu_op_o = ALU_SUB;
      CL_MVN:  alu_op_o = ALU_NOTB;
      default: alu_op_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Control FSM for the simple RISC datapath: latches an instruction on the
// start handshake and steps register read, operate and write-back.
module cpu_sequencer
  import cpu_pkg::*;
(
  input  logic           clk,
  input  logic           reset_n,
  cpu_sequencer_if.slave bus
);

  state_t      state_q, state_d;
  logic [15:0] ir_q, ir_d;
  logic [15:0] retire_q, retire_d;

  logic [2:0]  rn_s, rd_s, rm_s;
  logic [1:0]  sh_s, alu_op_s;
  logic [15:0] sximm8_s;
  iclass_t     iclass_s;

  cpu_decode u_decode (
    .ir_i     (ir_q),
    .rn_o     (rn_s),
    .rd_o     (rd_s),
    .rm_o     (rm_s),
    .sh_o     (sh_s),
    .sximm8_o (sximm8_s),
    .iclass_o (iclass_s),
    .alu_op_o (alu_op_s)
  );

  assign bus.sximm8       = sximm8_s;
  assign bus.retire_count = retire_q;

  // State, instruction and retire-count registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_WAIT;
      ir_q     <= 16'h0000;
      retire_q <= 16'h0000;
    end else begin
      state_q  <= state_d;
      ir_q     <= ir_d;
      retire_q <= retire_d;
    end
  end

  // Next state and Moore control outputs, decoded from state and ir only.
  always_comb begin
    state_d     = state_q;
    ir_d        = ir_q;
    retire_d    = retire_q;
    bus.w       = 1'b0;
    bus.illegal = 1'b0;
    bus.rnum    = 3'd0;
    bus.write   = 1'b0;
    bus.vsel    = 1'b0;
    bus.loada   = 1'b0;
    bus.loadb   = 1'b0;
    bus.loadc   = 1'b0;
    bus.loads   = 1'b0;
    bus.asel    = 1'b0;
    bus.shift   = 2'b00;
    bus.ALUop   = 2'b00;
    case (state_q)
      ST_WAIT: begin
        bus.w = 1'b1;
        if (bus.s) begin
          ir_d    = bus.instr;
          state_d = ST_DECODE;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_DECODE: begin
        case (iclass_s)
          CL_MOVI:         state_d = ST_WRITE_IMM;
          CL_MOVR, CL_MVN: state_d = ST_GET_B;
          CL_ALU3, CL_CMP: state_d = ST_GET_A;
          default: begin
            bus.illegal = 1'b1;
            state_d     = ST_WAIT;
          end
        endcase
      end
      ST_GET_A: begin
        bus.rnum  = rn_s;
        bus.loada = 1'b1;
        state_d   = ST_GET_B;
      end
      ST_GET_B: begin
        bus.rnum  = rm_s;
        bus.loadb = 1'b1;
        state_d   = ST_ALU;
      end
      ST_ALU: begin
        bus.shift = sh_s;
        bus.ALUop = alu_op_s;
        bus.asel  = (iclass_s == CL_MOVR);
        if (iclass_s == CL_CMP) begin
          bus.loads = 1'b1;
          retire_d  = retire_q + 16'd1;
          state_d   = ST_WAIT;
        end else begin
          bus.loadc = 1'b1;
          state_d   = ST_WRITE_REG;
        end
      end
      ST_WRITE_REG: begin
        bus.rnum  = rd_s;
        bus.write = 1'b1;
        retire_d  = retire_q + 16'd1;
        state_d   = ST_WAIT;
      end
      ST_WRITE_IMM: begin
        bus.rnum  = rn_s;
        bus.vsel  = 1'b1;
        bus.write = 1'b1;
        retire_d  = retire_q + 16'd1;
        state_d   = ST_WAIT;
      end
      default: state_d = ST_WAIT;
    endcase
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer: per-cycle expected control vectors are
// queued at instruction accept and compared on every falling edge.
module tb_cpu_sequencer;

  logic clk;
  logic reset_n;
  cpu_sequencer_if bus ();

  cpu_sequencer dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [15:0] ctl;
    logic [15:0] sx;
    logic [15:0] rc;
  } exp_t;

  exp_t        sb_q[$];
  int          total_cnt;
  int          bad_cnt;
  logic [15:0] exp_rc;
  logic [15:0] exp_sx;
  logic [15:0] ctl_s;

  // Packing: {w, illegal, rnum, write, vsel, loada, loadb, loadc, loads, asel, shift, ALUop}
  assign ctl_s = {bus.w, bus.illegal, bus.rnum, bus.write, bus.vsel, bus.loada,
                  bus.loadb, bus.loadc, bus.loads, bus.asel, bus.shift, bus.ALUop};

  function automatic logic [15:0] cv(input logic w, il, input logic [2:0] rn,
                                     input logic wr, vs, la, lb, lc, ls, as,
                                     input logic [1:0] sh, op);
    return {w, il, rn, wr, vs, la, lb, lc, ls, as, sh, op};
  endfunction

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push(input string tag, input logic [15:0] ctl);
    exp_t e;
    e.tag = tag;
    e.ctl = ctl;
    e.sx  = exp_sx;
    e.rc  = exp_rc;
    sb_q.push_back(e);
  endtask

  // Compare one queued expectation per cycle, away from the rising edge.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      check({e.tag, "_ctl"}, ctl_s, e.ctl);
      check({e.tag, "_sximm8"}, bus.sximm8, e.sx);
      check({e.tag, "_retire"}, bus.retire_count, e.rc);
    end
  end

  localparam logic [15:0] W_ONLY = 16'h8000;
  localparam logic [15:0] NONE   = 16'h0000;

  // Starts one instruction in the current WAIT cycle and queues its whole
  // cycle-by-cycle expectation; returns inside the following WAIT cycle.
  task automatic issue(input logic [15:0] v);
    logic [2:0] opc, rn, rd, rm;
    logic [1:0] op, sh;
    logic       movi, movr, alu, cmp, mvn;
    int         n;
    bus.s     = 1'b1;
    bus.instr = v;
    @(posedge clk);
    #1;
    bus.s     = 1'b0;
    bus.instr = 16'($urandom);
    opc  = v[15:13];
    op   = v[12:11];
    rn   = v[10:8];
    rd   = v[7:5];
    sh   = v[4:3];
    rm   = v[2:0];
    movi = (opc == 3'b110) && (op == 2'b10);
    movr = (opc == 3'b110) && (op == 2'b00);
    alu  = (opc == 3'b101);
    cmp  = alu && (op == 2'b01);
    mvn  = alu && (op == 2'b11);
    exp_sx = {{8{v[7]}}, v[7:0]};
    n = 0;
    if (!(movi || movr || alu)) begin
      push("decode_ill", cv(1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0));
      n++;
    end else begin
      push("decode", NONE);
      n++;
      if (movi) begin
        push("write_imm", cv(1'b0, 1'b0, rn, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0));
        n++;
      end else begin
        if (alu && !mvn) begin
          push("get_a", cv(1'b0, 1'b0, rn, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0));
          n++;
        end
        push("get_b", cv(1'b0, 1'b0, rm, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0));
        n++;
        push("alu", cv(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, !cmp, cmp, movr, sh,
                       movr ? 2'b00 : op));
        n++;
        if (!cmp) begin
          push("write_reg", cv(1'b0, 1'b0, rd, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0));
          n++;
        end
      end
      exp_rc = exp_rc + 16'd1;
    end
    push("wait", W_ONLY);
    n++;
    // Random start pulses while busy must be ignored.
    for (int k = 1; k < n; k++) begin
      bus.s     = 1'($urandom_range(0, 1));
      bus.instr = 16'($urandom);
      @(posedge clk);
      #1;
    end
    bus.s = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      push("idle", W_ONLY);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, time=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] v;
    total_cnt = 0;
    bad_cnt   = 0;
    exp_rc    = 16'h0000;
    exp_sx    = 16'h0000;
    reset_n   = 1'b0;
    bus.s     = 1'b0;
    bus.instr = 16'h0000;
    #1;
    check("rst_ctl", ctl_s, W_ONLY);
    check("rst_sximm8", bus.sximm8, 16'h0000);
    check("rst_retire", bus.retire_count, 16'h0000);
    @(negedge clk);
    reset_n = 1'b1;

    issue(16'hD007);
    issue(16'hD1FE);
    issue(16'hA148);
    issue(16'hA900);
    issue(16'hB860);
    issue(16'h0000);
    idle(2);
    issue(16'hC0CA);
    issue(16'hB143);
    issue(16'hC800);
    issue(16'hE000);
    idle(1);
    for (int i = 0; i < 24; i++) begin
      v = 16'($urandom);
      case ($urandom_range(0, 2))
        0:       v[15:13] = 3'b110;
        1:       v[15:13] = 3'b101;
        default: v[15:13] = v[15:13];
      endcase
      issue(v);
    end

    // Reset pulled during GET_B of an ADD.
    bus.s     = 1'b1;
    bus.instr = 16'hA148;
    @(posedge clk);
    #1;
    bus.s = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check("getb_before_rst", ctl_s, cv(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0));
    #2;
    reset_n = 1'b0;
    #1;
    check("midrst_ctl", ctl_s, W_ONLY);
    check("midrst_retire", bus.retire_count, 16'h0000);
    check("midrst_sximm8", bus.sximm8, 16'h0000);
    exp_rc = 16'h0000;
    exp_sx = 16'h0000;
    @(negedge clk);
    reset_n = 1'b1;
    issue(16'hA900);
    issue(16'hD37F);
    idle(2);

    for (int k = 0; k < 4 && sb_q.size() > 0; k++) @(posedge clk);
    @(negedge clk);
    #1;
    if (sb_q.size() != 0) begin
      bad_cnt++;
      $display("FAIL drain: queued=%0d expected=0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
